// File: rtl/darkbus_pkg.sv
// ----------------------------------------------------------------------------
// darkbus_pkg: shared states, default widths and round-robin index helper. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package darkbus_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int DEF_N_PROV  = 2;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 255;

  function automatic int rr_idx(input int last, input int off, input int n);
    return (last + off) % n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/darkbus_rr_pick.sv
// ----------------------------------------------------------------------------
// darkbus_rr_pick: combinational round-robin picker starting after last. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module darkbus_rr_pick import darkbus_pkg::*; #(
  parameter int N  = DEF_N_PROV,
  parameter int IW = $clog2(DEF_N_PROV)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] winner,
  output logic          valid
);

  logic [IW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester after
  // 'last' is written last and therefore wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'(rr_idx(int'(last), k, N));
      if (req[cand]) begin
        winner = cand;
        valid  = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/darkbus_arbiter.sv
// ----------------------------------------------------------------------------
// darkbus_arbiter: N-provider to 1-consumer round-robin darkbus arbiter. Rev 1.0
// Optional: define DARKBUS_TIMEOUT_EN for an ack timeout with error response.
// ----------------------------------------------------------------------------
`default_nettype none

module darkbus_arbiter import darkbus_pkg::*; #(
  parameter int N_PROV  = DEF_N_PROV,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           resn,
  input  logic [N_PROV-1:0]              p_en,
  input  logic [N_PROV-1:0]              p_re,
  input  logic [N_PROV-1:0]              p_we,
  input  logic [N_PROV*(DATA_W/8)-1:0]   p_be,
  input  logic [N_PROV*ADDR_W-1:0]       p_addr,
  input  logic [N_PROV*DATA_W-1:0]       p_wdata,
  output logic [DATA_W-1:0]              p_rdata,
  output logic [N_PROV-1:0]              p_rack,
  output logic [N_PROV-1:0]              p_wack,
  output logic [N_PROV-1:0]              p_err,
  output logic                           c_en,
  output logic                           c_re,
  output logic                           c_we,
  output logic [DATA_W/8-1:0]            c_be,
  output logic [ADDR_W-1:0]              c_addr,
  output logic [DATA_W-1:0]              c_wdata,
  input  logic [DATA_W-1:0]              c_rdata,
  input  logic                           c_rack,
  input  logic                           c_wack,
  output logic [$clog2(N_PROV)-1:0]      gnt
);

  localparam int BW = DATA_W / 8;
  localparam int IW = $clog2(N_PROV);

  state_t        state, state_nx;
  logic [IW-1:0] last, gnt_nx, last_nx, pick;
  logic          pick_vld;
  logic          sel_en, ack, timeout_hit;

  logic [BW-1:0]     be_arr    [N_PROV];
  logic [ADDR_W-1:0] addr_arr  [N_PROV];
  logic [DATA_W-1:0] wdata_arr [N_PROV];

  generate
    for (genvar i = 0; i < N_PROV; i++) begin : g_unpack
      assign be_arr[i]    = p_be[i*BW +: BW];
      assign addr_arr[i]  = p_addr[i*ADDR_W +: ADDR_W];
      assign wdata_arr[i] = p_wdata[i*DATA_W +: DATA_W];
    end
  endgenerate

  darkbus_rr_pick #(
    .N  (N_PROV),
    .IW (IW)
  ) u_pick (
    .req    (p_en),
    .last   (last),
    .winner (pick),
    .valid  (pick_vld)
  );

  assign sel_en  = (state == BUSY) && p_en[gnt];
  assign ack     = c_rack | c_wack;
  assign p_rdata = c_rdata;

`ifdef DARKBUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] to_cnt;

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      to_cnt <= '0;
    end else if (state == IDLE) begin
      to_cnt <= '0;
    end else if (!ack) begin
      to_cnt <= to_cnt + CW'(1);
    end
  end

  // A consumer ack on the expiry cycle takes precedence over the error.
  assign timeout_hit = sel_en && !ack && (to_cnt == CW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state <= IDLE;
      gnt   <= '0;
      last  <= IW'(N_PROV - 1);
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      last  <= last_nx;
    end
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    last_nx  = last;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nx = BUSY;
          gnt_nx   = pick;
          last_nx  = pick;
        end
      end
      BUSY: begin
        if (!p_en[gnt] || ack || timeout_hit) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    c_en    = 1'b0;
    c_re    = 1'b0;
    c_we    = 1'b0;
    c_be    = '0;
    c_addr  = '0;
    c_wdata = '0;
    p_rack  = '0;
    p_wack  = '0;
    p_err   = '0;
    if (state == BUSY) begin
      c_be    = be_arr[gnt];
      c_addr  = addr_arr[gnt];
      c_wdata = wdata_arr[gnt];
      if (sel_en && !timeout_hit) begin
        c_en = 1'b1;
        c_re = p_re[gnt];
        c_we = p_we[gnt];
      end
      // An aborted provider gets no ack even if the consumer answers late.
      if (sel_en) begin
        p_rack[gnt] = c_rack | (timeout_hit & p_re[gnt]);
        p_wack[gnt] = c_wack | (timeout_hit & p_we[gnt]);
        p_err[gnt]  = timeout_hit;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_darkbus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_darkbus_arbiter: directed self-checking bench for darkbus_arbiter. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_darkbus_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              resn = 1'b0;
  logic [N-1:0]      p_en = '0, p_re = '0, p_we = '0;
  logic [N*BW-1:0]   p_be = '0;
  logic [N*AW-1:0]   p_addr = '0;
  logic [N*DW-1:0]   p_wdata = '0;
  logic [DW-1:0]     p_rdata;
  logic [N-1:0]      p_rack, p_wack, p_err;
  logic              c_en, c_re, c_we;
  logic [BW-1:0]     c_be;
  logic [AW-1:0]     c_addr;
  logic [DW-1:0]     c_wdata;
  logic [DW-1:0]     c_rdata = 32'h0000_55AA;
  logic              c_rack = 1'b0, c_wack = 1'b0;
  logic [1:0]        gnt;

  int n_cmp = 0;
  int n_err = 0;

  darkbus_arbiter #(
    .N_PROV (N), .ADDR_W (AW), .DATA_W (DW), .TIMEOUT (TO)
  ) dut (
    .clk (clk), .resn (resn),
    .p_en (p_en), .p_re (p_re), .p_we (p_we), .p_be (p_be),
    .p_addr (p_addr), .p_wdata (p_wdata), .p_rdata (p_rdata),
    .p_rack (p_rack), .p_wack (p_wack), .p_err (p_err),
    .c_en (c_en), .c_re (c_re), .c_we (c_we), .c_be (c_be),
    .c_addr (c_addr), .c_wdata (c_wdata), .c_rdata (c_rdata),
    .c_rack (c_rack), .c_wack (c_wack), .gnt (gnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    p_en = '0; p_re = '0; p_we = '0; p_be = '0; p_addr = '0; p_wdata = '0;
    c_rack = 1'b0; c_wack = 1'b0;
  endtask

  task automatic do_reset();
    resn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 resn = 1'b1;
  endtask

  int ord [5] = '{0, 1, 2, 3, 0};

  initial begin
    // Reset state
    mid();
    check("rst_cen", c_en, 0);
    check("rst_gnt", gnt, 0);
    check("rst_rack", p_rack, 0);
    check("rst_wack", p_wack, 0);
    check("rst_err", p_err, 0);
    check("rst_caddr", c_addr, 0);
    check("rst_rdata_pass", p_rdata, 32'h0000_55AA);

    // Single read from provider 1
    do_reset();
    p_en[1] = 1'b1; p_re[1] = 1'b1; p_addr[AW +: AW] = 32'h100; p_be[BW +: BW] = 4'hF;
    mid();
    check("rd_idle_cen", c_en, 0);
    cyc(); mid();
    check("rd_cen", c_en, 1);
    check("rd_cre", c_re, 1);
    check("rd_caddr", c_addr, 32'h100);
    check("rd_gnt", gnt, 1);
    cyc(); mid();
    check("rd_wait_cen", c_en, 1);
    check("rd_wait_rack", p_rack, 0);
    cyc(); c_rack = 1'b1; c_rdata = 32'hDEAD_BEEF; mid();
    check("rd_rack", p_rack, 4'b0010);
    check("rd_rdata", p_rdata, 32'hDEAD_BEEF);
    check("rd_wack", p_wack, 0);
    cyc(); c_rack = 1'b0; p_en = '0; p_re = '0; mid();
    check("rd_after_cen", c_en, 0);
    check("rd_after_rack", p_rack, 0);

    // Four-way contention, consumer acks immediately
    do_reset();
    p_en = 4'hF; p_re = 4'hF;
    for (int i = 0; i < N; i++) p_addr[i*AW +: AW] = 32'h1000 + i;
    for (int k = 0; k < 5; k++) begin
      c_rack = 1'b0; mid();
      check("rr_dead_cen", c_en, 0);
      cyc(); c_rack = 1'b1; mid();
      check("rr_gnt", gnt, ord[k]);
      check("rr_caddr", c_addr, 32'h1000 + ord[k]);
      check("rr_rack", p_rack, 64'(1) << ord[k]);
      cyc();
    end
    clear_inputs();

    // Write with partial byte enables from provider 2
    do_reset();
    p_en[2] = 1'b1; p_we[2] = 1'b1; p_be[2*BW +: BW] = 4'b0011; p_wdata[2*DW +: DW] = 32'h1234_5678;
    mid(); cyc(); c_wack = 1'b1; mid();
    check("wr_gnt", gnt, 2);
    check("wr_cwe", c_we, 1);
    check("wr_cre", c_re, 0);
    check("wr_cbe", c_be, 4'b0011);
    check("wr_cwdata", c_wdata, 32'h1234_5678);
    check("wr_wack", p_wack, 4'b0100);
    check("wr_rack", p_rack, 0);
    cyc(); clear_inputs(); mid();
    check("wr_after_cen", c_en, 0);

    // Abort by provider 0, provider 1 follows
    do_reset();
    p_en = 4'b0011; p_re = 4'b0011;
    mid(); cyc(); mid();
    check("ab_gnt0", gnt, 0);
    check("ab_cen", c_en, 1);
    cyc(); p_en[0] = 1'b0; p_re[0] = 1'b0; mid();
    check("ab_drop_cen", c_en, 0);
    check("ab_drop_rack", p_rack, 0);
    cyc(); mid();
    check("ab_idle_cen", c_en, 0);
    cyc(); mid();
    check("ab_gnt1", gnt, 1);
    check("ab_cen1", c_en, 1);
    cyc(); c_rack = 1'b1; mid();
    check("ab_rack1", p_rack, 4'b0010);
    cyc(); clear_inputs();

`ifdef DARKBUS_TIMEOUT_EN
    // Consumer never acks: error response on the 8th busy cycle
    do_reset();
    p_en[0] = 1'b1; p_re[0] = 1'b1;
    mid(); cyc();
    for (int k = 1; k < TO; k++) begin
      mid();
      check("to_wait_cen", c_en, 1);
      check("to_wait_err", p_err, 0);
      cyc();
    end
    mid();
    check("to_rack", p_rack, 4'b0001);
    check("to_err", p_err, 4'b0001);
    check("to_cen", c_en, 0);
    cyc(); clear_inputs(); mid();
    check("to_after_rack", p_rack, 0);

    // Consumer ack on the expiry cycle wins
    do_reset();
    p_en[0] = 1'b1; p_re[0] = 1'b1;
    mid(); cyc();
    repeat (TO - 1) cyc();
    c_rack = 1'b1; mid();
    check("to_race_rack", p_rack, 4'b0001);
    check("to_race_err", p_err, 0);
    check("to_race_cen", c_en, 1);
    cyc(); clear_inputs();
`endif

    // Asynchronous reset during a transaction
    do_reset();
    p_en[3] = 1'b1; p_re[3] = 1'b1;
    mid(); cyc(); mid();
    check("ar_gnt3", gnt, 3);
    check("ar_cen", c_en, 1);
    #1; resn = 1'b0; c_rack = 1'b1;
    #1;
    check("ar_cen_low", c_en, 0);
    check("ar_cre_low", c_re, 0);
    check("ar_rack_low", p_rack, 0);
    check("ar_gnt_rst", gnt, 0);
    c_rack = 1'b0; p_en = 4'hF; p_re = 4'hF;
    cyc(); cyc(); resn = 1'b1; mid();
    check("ar_rel_cen", c_en, 0);
    cyc(); mid();
    check("ar_first_gnt", gnt, 0);
    check("ar_first_cen", c_en, 1);
    clear_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
